// File: rtl/ser_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ser_arb_pkg
// Purpose : types and helpers shared by the serializer arbiter slice.
// Contents: state_t   - scheduler states (IDLE, WAIT_BUSY, WAIT_DONE)
//           MOD_MIN   - smallest bit count that is forwarded to the serializer
//           next_ptr  - round-robin pointer increment modulo the requester count
// ---------------------------------------------------------------------------
package ser_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  localparam int unsigned MOD_MIN = 3;

  // Explicit wrap instead of '%' so non-power-of-2 counts stay cheap.
  function automatic int unsigned next_ptr(input int unsigned cur, input int unsigned n);
    return (cur + 1 >= n) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/ser_arbiter_if.sv
// ---------------------------------------------------------------------------
// ser_arbiter_if
// Purpose : bundles the requester handshake and serializer load/busy signals.
// Modports: slave  - the arbiter (consumes requests, drives the serializer)
//           master - the environment (packet sources + serializer)
// Signals : req_val_i/req_mod_i/req_data_i/req_ready_o  per-requester handshake
//           ser_busy_i/ser_val_o/ser_mod_o/ser_word_o    serializer load side
//           grant_idx_o/drop_o/err_o                     status
// ---------------------------------------------------------------------------
interface ser_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 16,
  parameter int MOD_W  = 4
);
  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        req_val_i;
  logic [N_REQ*MOD_W-1:0]  req_mod_i;
  logic [N_REQ*DATA_W-1:0] req_data_i;
  logic [N_REQ-1:0]        req_ready_o;
  logic                    ser_busy_i;
  logic                    ser_val_o;
  logic [MOD_W-1:0]        ser_mod_o;
  logic [DATA_W-1:0]       ser_word_o;
  logic [IDX_W-1:0]        grant_idx_o;
  logic                    drop_o;
  logic                    err_o;

  modport slave (
    input  req_val_i, req_mod_i, req_data_i, ser_busy_i,
    output req_ready_o, ser_val_o, ser_mod_o, ser_word_o, grant_idx_o, drop_o, err_o
  );

  modport master (
    output req_val_i, req_mod_i, req_data_i, ser_busy_i,
    input  req_ready_o, ser_val_o, ser_mod_o, ser_word_o, grant_idx_o, drop_o, err_o
  );

endinterface

// File: rtl/ser_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purpose : combinational round-robin pick among pending requests.
// Ports   : req     in  N_REQ  pending requests
//           ptr     in  IDX_W  highest-priority index (must be < N_REQ)
//           winner  out IDX_W  first set req at or after ptr, with wrap
//           any_req out 1      at least one request pending
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any_req
);

  // Rotate so that slot 0 is the requester at ptr; ptr < N_REQ keeps the sum
  // below 2*N_REQ, so a single conditional subtract is enough to wrap.
  logic [IDX_W-1:0] rot_idx [N_REQ];
  logic [N_REQ-1:0] rot_req;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
      logic [IDX_W:0] pos;
      assign pos          = {1'b0, ptr} + (IDX_W+1)'(gi);
      assign rot_idx[gi]  = (pos >= (IDX_W+1)'(N_REQ)) ?
                            IDX_W'(pos - (IDX_W+1)'(N_REQ)) : pos[IDX_W-1:0];
      assign rot_req[gi]  = req[rot_idx[gi]];
    end
  endgenerate

  // Descending scan: the lowest rotated slot that is set wins.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot_req[k]) begin
        winner  = rot_idx[k];
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ser_arbiter.sv
// ---------------------------------------------------------------------------
// ser_arbiter
// Purpose : shares one serializer between N_REQ requesters. Each requester
//           owns a one-word holding buffer; a round-robin scheduler launches
//           buffered words with a one-cycle load strobe and then follows the
//           serializer busy flag until the word has been shifted out.
// Ports   : clk_i   in  clock
//           srst_i  in  synchronous active-high reset
//           bus     ser_arbiter_if.slave (requester handshake, serializer
//                   load/busy, grant index, drop and timeout pulses)
// ---------------------------------------------------------------------------
module ser_arbiter
  import ser_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 16,
  parameter int MOD_W    = 4,
  parameter int BUSY_TMO = 2
) (
  input  logic          clk_i,
  input  logic          srst_i,
  ser_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int TMO_W = $clog2(BUSY_TMO + 1);
  localparam logic [MOD_W-1:0] MOD_MIN_W = MOD_W'(MOD_MIN);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(BUSY_TMO - 1);

  logic [N_REQ-1:0]  full;
  logic [DATA_W-1:0] buf_data [N_REQ];
  logic [MOD_W-1:0]  buf_mod  [N_REQ];

  logic [IDX_W-1:0]  ptr_reg, ptr_next;
  logic [IDX_W-1:0]  winner;
  logic              any_req;

  state_t            state_reg, state_next;
  logic [TMO_W-1:0]  tmo_reg, tmo_next;
  logic              launch, drop, tmo_err;

  logic              ser_val_reg;
  logic [DATA_W-1:0] word_reg;
  logic [MOD_W-1:0]  mod_reg;
  logic [IDX_W-1:0]  grant_reg;
  logic              drop_reg;
  logic              err_reg;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req     (full),
    .ptr     (ptr_reg),
    .winner  (winner),
    .any_req (any_req)
  );

  // ---------------------------------------------------------------- buffers
  // A launched buffer stays full through the strobe cycle and is released at
  // the edge that ends it, so ready returns the cycle after the strobe.
  // Dropped words are released immediately at the decision edge.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_buf
      logic              full_q;
      logic [DATA_W-1:0] data_q;
      logic [MOD_W-1:0]  mod_q;
      logic              load, clr;

      assign load = bus.req_val_i[gi] && !full_q;
      assign clr  = (drop && (winner == IDX_W'(gi))) ||
                    (ser_val_reg && (grant_reg == IDX_W'(gi)));

      always_ff @(posedge clk_i) begin
        if (srst_i) begin
          full_q <= 1'b0;
        end else if (clr) begin
          full_q <= 1'b0;
        end else if (load) begin
          full_q <= 1'b1;
        end
      end

      always_ff @(posedge clk_i) begin
        if (load) begin
          data_q <= bus.req_data_i[gi*DATA_W +: DATA_W];
          mod_q  <= bus.req_mod_i[gi*MOD_W +: MOD_W];
        end
      end

      assign full[gi]     = full_q;
      assign buf_data[gi] = data_q;
      assign buf_mod[gi]  = mod_q;
    end
  endgenerate

  // -------------------------------------------------------------------- FSM
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_reg <= IDLE;
      tmo_reg   <= '0;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      tmo_reg   <= tmo_next;
      ptr_reg   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    tmo_next   = tmo_reg;
    launch     = 1'b0;
    drop       = 1'b0;
    tmo_err    = 1'b0;
    case (state_reg)
      IDLE: begin
        tmo_next = '0;
        if (any_req) begin
          if (buf_mod[winner] >= MOD_MIN_W) begin
            launch     = 1'b1;
            state_next = WAIT_BUSY;
          end else begin
            drop = 1'b1;
          end
        end
      end
      WAIT_BUSY: begin
        // Busy wins over the timeout when both land on the same edge.
        if (bus.ser_busy_i) begin
          state_next = WAIT_DONE;
        end else if (tmo_reg == TMO_LAST) begin
          tmo_err    = 1'b1;
          state_next = IDLE;
        end else begin
          tmo_next = tmo_reg + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!bus.ser_busy_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign ptr_next = (launch || drop) ? IDX_W'(next_ptr(32'(winner), N_REQ)) : ptr_reg;

  // ------------------------------------------------------ registered outputs
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      ser_val_reg <= 1'b0;
      word_reg    <= '0;
      mod_reg     <= '0;
      grant_reg   <= '0;
      drop_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      ser_val_reg <= launch;
      drop_reg    <= drop;
      err_reg     <= tmo_err;
      if (launch) begin
        word_reg  <= buf_data[winner];
        mod_reg   <= buf_mod[winner];
        grant_reg <= winner;
      end
    end
  end

  assign bus.req_ready_o = ~full;
  assign bus.ser_val_o   = ser_val_reg;
  assign bus.ser_word_o  = word_reg;
  assign bus.ser_mod_o   = mod_reg;
  assign bus.grant_idx_o = grant_reg;
  assign bus.drop_o      = drop_reg;
  assign bus.err_o       = err_reg;

endmodule

// File: tb/tb_ser_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ser_arbiter
// Purpose : self-checking bench for ser_arbiter. Contains a behavioural
//           serializer (loads on strobe, shifts MSB first, busy while
//           shifting) or a hand-driven busy flag, a table of single-word
//           vectors, directed multi-cycle sequences and a randomized run
//           checked against per-requester word queues and an expected bit
//           stream.
// ---------------------------------------------------------------------------
module tb_ser_arbiter;

  localparam int N_REQ    = 4;
  localparam int DATA_W   = 16;
  localparam int MOD_W    = 4;
  localparam int BUSY_TMO = 2;

  logic clk = 1'b0;
  logic srst;
  always #5 clk = ~clk;

  ser_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W), .MOD_W(MOD_W)) bus ();

  ser_arbiter #(
    .N_REQ(N_REQ), .DATA_W(DATA_W), .MOD_W(MOD_W), .BUSY_TMO(BUSY_TMO)
  ) dut (
    .clk_i  (clk),
    .srst_i (srst),
    .bus    (bus)
  );

  // busy source: 1 = behavioural serializer, 0 = manual flag
  logic        stub_mode;
  logic        busy_man;
  logic        stub_busy;
  logic        stub_bit;
  logic        stub_bit_val;
  logic [15:0] stub_sh;
  logic [3:0]  stub_cnt;

  assign bus.ser_busy_i = stub_mode ? stub_busy : busy_man;

  always @(posedge clk) begin
    if (srst) begin
      stub_busy    <= 1'b0;
      stub_bit_val <= 1'b0;
      stub_bit     <= 1'b0;
      stub_sh      <= '0;
      stub_cnt     <= '0;
    end else begin
      stub_bit_val <= 1'b0;
      if (stub_busy) begin
        stub_bit     <= stub_sh[15];
        stub_bit_val <= 1'b1;
        stub_sh      <= {stub_sh[14:0], 1'b0};
        stub_cnt     <= stub_cnt - 4'd1;
        if (stub_cnt == 4'd1) stub_busy <= 1'b0;
      end else if (bus.ser_val_o && stub_mode) begin
        stub_sh   <= bus.ser_word_o;
        stub_cnt  <= bus.ser_mod_o;
        stub_busy <= 1'b1;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    srst           = 1'b1;
    bus.req_val_i  = '0;
    busy_man       = 1'b0;
    tick();
    tick();
    srst = 1'b0;
  endtask

  task automatic put_req(input int idx, input logic [15:0] data, input logic [3:0] mod);
    bus.req_val_i[idx]            = 1'b1;
    bus.req_data_i[idx*16 +: 16]  = data;
    bus.req_mod_i[idx*4 +: 4]     = mod;
  endtask

  typedef struct {
    int          idx;
    logic [3:0]  mod;
    logic [15:0] data;
    logic        exp_launch;
    logic [1:0]  exp_grant;
    logic [15:0] exp_word;
    logic [3:0]  exp_mod;
  } vec_t;

  vec_t vecs [7];

  // reference model state for the randomized run
  logic [15:0] mq_data [N_REQ][$];
  logic [3:0]  mq_mod  [N_REQ][$];
  logic        exp_bits [$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_bad, lat, gcount, nbits;
    logic got_s, got_d;
    logic [N_REQ-1:0] pend, rdy_snap, val_drv;
    logic [15:0] pdata [N_REQ];
    logic [3:0]  pmod  [N_REQ];
    logic [15:0] w;
    logic [3:0]  m;

    srst           = 1'b1;
    stub_mode      = 1'b0;
    busy_man       = 1'b0;
    bus.req_val_i  = '0;
    bus.req_data_i = '0;
    bus.req_mod_i  = '0;

    // ---------------------------------------------------- reset state
    do_reset();
    check("rst_ready", 32'(bus.req_ready_o), 32'hF);
    check("rst_ser_val", 32'(bus.ser_val_o), 0);
    check("rst_word", 32'(bus.ser_word_o), 0);
    check("rst_mod", 32'(bus.ser_mod_o), 0);
    check("rst_grant", 32'(bus.grant_idx_o), 0);
    check("rst_drop", 32'(bus.drop_o), 0);
    check("rst_err", 32'(bus.err_o), 0);

    // ---------------------------------------------------- single word, manual busy
    put_req(0, 16'hA5F0, 4'd8);
    tick();                                   // accept edge t
    bus.req_val_i = '0;
    check("t1_ready_t1", 32'(bus.req_ready_o[0]), 0);
    check("t1_noval_t1", 32'(bus.ser_val_o), 0);
    tick();
    check("t1_val_t2", 32'(bus.ser_val_o), 1);
    check("t1_word", 32'(bus.ser_word_o), 32'hA5F0);
    check("t1_mod", 32'(bus.ser_mod_o), 8);
    check("t1_grant", 32'(bus.grant_idx_o), 0);
    check("t1_ready_t2", 32'(bus.req_ready_o[0]), 0);
    busy_man = 1'b1;
    tick();
    check("t1_val_pulse", 32'(bus.ser_val_o), 0);
    check("t1_ready_t3", 32'(bus.req_ready_o[0]), 1);
    put_req(1, 16'h1111, 4'd5);
    tick();
    bus.req_val_i = '0;
    n_bad = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.ser_val_o) n_bad++;
    end
    check("t1_blocked_busy", 32'(n_bad), 0);
    busy_man = 1'b0;
    tick();
    check("t1_no_early", 32'(bus.ser_val_o), 0);
    tick();
    check("t1_second_val", 32'(bus.ser_val_o), 1);
    check("t1_second_grant", 32'(bus.grant_idx_o), 1);
    check("t1_second_word", 32'(bus.ser_word_o), 32'h1111);
    repeat (6) tick();

    // ---------------------------------------------------- vector table
    vecs[0] = '{0, 4'd8,  16'hA5F0, 1'b1, 2'd0, 16'hA5F0, 4'd8};
    vecs[1] = '{2, 4'd2,  16'h1234, 1'b0, 2'd0, 16'hA5F0, 4'd8};
    vecs[2] = '{3, 4'd3,  16'hBEEF, 1'b1, 2'd3, 16'hBEEF, 4'd3};
    vecs[3] = '{1, 4'd15, 16'h8001, 1'b1, 2'd1, 16'h8001, 4'd15};
    vecs[4] = '{3, 4'd0,  16'h0000, 1'b0, 2'd1, 16'h8001, 4'd15};
    vecs[5] = '{0, 4'd1,  16'h7777, 1'b0, 2'd1, 16'h8001, 4'd15};
    vecs[6] = '{2, 4'd12, 16'hC3C3, 1'b1, 2'd2, 16'hC3C3, 4'd12};
    stub_mode = 1'b1;
    do_reset();
    for (int v = 0; v < 7; v++) begin
      put_req(vecs[v].idx, vecs[v].data, vecs[v].mod);
      tick();
      bus.req_val_i = '0;
      lat = 0; got_s = 1'b0; got_d = 1'b0;
      for (int k = 1; k <= 8; k++) begin
        tick();
        if (bus.ser_val_o || bus.drop_o) begin
          lat = k; got_s = bus.ser_val_o; got_d = bus.drop_o;
          break;
        end
      end
      $display("vec %0d: req %0d mod %0d -> strobe %0d drop %0d grant %0d word %h",
               v, vecs[v].idx, vecs[v].mod, got_s, got_d, bus.grant_idx_o, bus.ser_word_o);
      check("vec_latency", 32'(lat), 1);
      check("vec_strobe", 32'(got_s), 32'(vecs[v].exp_launch));
      check("vec_drop", 32'(got_d), 32'(!vecs[v].exp_launch));
      check("vec_grant", 32'(bus.grant_idx_o), 32'(vecs[v].exp_grant));
      check("vec_word", 32'(bus.ser_word_o), 32'(vecs[v].exp_word));
      check("vec_mod", 32'(bus.ser_mod_o), 32'(vecs[v].exp_mod));
      repeat (24) tick();
    end

    // ---------------------------------------------------- fairness, all full
    stub_mode = 1'b1;
    do_reset();
    gcount = 0;
    for (int c = 0; c < 300 && gcount < 8; c++) begin
      bus.req_val_i  = bus.req_ready_o;
      bus.req_mod_i  = 16'h4444;
      bus.req_data_i = {$urandom, $urandom};
      tick();
      if (bus.ser_val_o) begin
        $display("fair: grant %0d", bus.grant_idx_o);
        check("fair_grant", 32'(bus.grant_idx_o), 32'(gcount % 4));
        check("fair_not_busy", 32'(bus.ser_busy_i), 0);
        gcount++;
      end
    end
    check("fair_count", 32'(gcount), 8);
    bus.req_val_i = '0;
    repeat (30) tick();

    // ---------------------------------------------------- invalid mod drop
    do_reset();
    put_req(2, 16'h2222, 4'd2);
    tick();
    bus.req_val_i = '0;
    tick();
    check("drop_pulse", 32'(bus.drop_o), 1);
    check("drop_no_val", 32'(bus.ser_val_o), 0);
    check("drop_ready", 32'(bus.req_ready_o), 32'hF);
    put_req(1, 16'h0101, 4'd3);
    put_req(3, 16'h0303, 4'd3);
    tick();
    bus.req_val_i = '0;
    check("drop_single", 32'(bus.drop_o), 0);
    tick();
    check("drop_next_val", 32'(bus.ser_val_o), 1);
    check("drop_next_grant", 32'(bus.grant_idx_o), 3);
    check("drop_next_word", 32'(bus.ser_word_o), 32'h0303);
    got_s = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (bus.ser_val_o) begin got_s = 1'b1; break; end
    end
    check("drop_then_req1", 32'(got_s), 1);
    check("drop_then_grant", 32'(bus.grant_idx_o), 1);
    repeat (10) tick();

    // ---------------------------------------------------- busy timeout
    stub_mode = 1'b0;
    do_reset();
    put_req(0, 16'hAAAA, 4'd5);
    put_req(1, 16'hBBBB, 4'd5);
    tick();
    bus.req_val_i = '0;
    tick();
    check("tmo_val", 32'(bus.ser_val_o), 1);
    check("tmo_grant0", 32'(bus.grant_idx_o), 0);
    tick();
    check("tmo_err_early", 32'(bus.err_o), 0);
    tick();
    check("tmo_err", 32'(bus.err_o), 1);
    tick();
    check("tmo_err_pulse", 32'(bus.err_o), 0);
    check("tmo_relaunch", 32'(bus.ser_val_o), 1);
    check("tmo_grant1", 32'(bus.grant_idx_o), 1);
    repeat (6) tick();

    // ---------------------------------------------------- reset mid-transfer
    do_reset();
    for (int i = 0; i < N_REQ; i++) put_req(i, 16'(16'h1000 * (i + 1)), 4'd6);
    tick();
    bus.req_val_i = '0;
    tick();
    check("mrst_val", 32'(bus.ser_val_o), 1);
    busy_man = 1'b1;
    tick();
    check("mrst_three_full", 32'(bus.req_ready_o), 32'h1);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    busy_man = 1'b0;
    check("mrst_ready", 32'(bus.req_ready_o), 32'hF);
    check("mrst_val0", 32'(bus.ser_val_o), 0);
    check("mrst_grant", 32'(bus.grant_idx_o), 0);
    check("mrst_word", 32'(bus.ser_word_o), 0);
    put_req(1, 16'h5A5A, 4'd7);
    tick();
    bus.req_val_i = '0;
    tick();
    check("mrst_launch", 32'(bus.ser_val_o), 1);
    check("mrst_launch_grant", 32'(bus.grant_idx_o), 1);
    repeat (6) tick();

    // ---------------------------------------------------- randomized, real serializer
    stub_mode = 1'b1;
    do_reset();
    pend  = '0;
    nbits = 0;
    exp_bits.delete();
    for (int i = 0; i < N_REQ; i++) begin
      mq_data[i].delete();
      mq_mod[i].delete();
      pdata[i] = '0;
      pmod[i]  = '0;
    end
    for (int cyc = 0; cyc < 1600; cyc++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!pend[i] && cyc < 1200 && $urandom_range(0, 3) == 0) begin
          pend[i]  = 1'b1;
          pdata[i] = 16'($urandom);
          pmod[i]  = 4'($urandom_range(3, 15));
        end
        bus.req_data_i[i*16 +: 16] = pdata[i];
        bus.req_mod_i[i*4 +: 4]    = pmod[i];
      end
      val_drv       = pend;
      bus.req_val_i = val_drv;
      rdy_snap      = bus.req_ready_o;
      tick();
      if (bus.ser_val_o) begin
        check("rnd_not_busy", 32'(bus.ser_busy_i), 0);
        check("rnd_queue_nonempty", 32'(mq_data[bus.grant_idx_o].size() > 0), 1);
        if (mq_data[bus.grant_idx_o].size() > 0) begin
          w = mq_data[bus.grant_idx_o].pop_front();
          m = mq_mod[bus.grant_idx_o].pop_front();
          $display("rnd: launch req %0d word %h mod %0d", bus.grant_idx_o, bus.ser_word_o, bus.ser_mod_o);
          check("rnd_word", 32'(bus.ser_word_o), 32'(w));
          check("rnd_mod", 32'(bus.ser_mod_o), 32'(m));
          for (int b = 0; b < int'(m); b++) exp_bits.push_back(w[15-b]);
        end
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (val_drv[i] && rdy_snap[i]) begin
          mq_data[i].push_back(pdata[i]);
          mq_mod[i].push_back(pmod[i]);
          pend[i] = 1'b0;
        end
      end
      if (stub_bit_val) begin
        nbits++;
        if (exp_bits.size() == 0) begin
          check("rnd_bit_expected", 0, 1);
        end else begin
          check("rnd_bit", 32'(stub_bit), 32'(exp_bits.pop_front()));
        end
      end
    end
    bus.req_val_i = '0;
    check("rnd_bits_seen", 32'(nbits > 0), 1);
    check("rnd_bits_left", 32'(exp_bits.size()), 0);
    for (int i = 0; i < N_REQ; i++) begin
      check("rnd_words_left", 32'(mq_data[i].size()), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
